// File: rtl/alu_bypass_if.sv
// ALU bypass unit bundle: operands, bypass sets, control and results.
// master drives operands/control, slave (the unit) drives results.
interface alu_bypass_if;
  logic [4:0]  RegA;
  logic [4:0]  RegB;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic [4:0]  FwdReg1;
  logic [31:0] FwdData1;
  logic        FwdValid1;
  logic [4:0]  FwdReg2;
  logic [31:0] FwdData2;
  logic        FwdValid2;
  logic [5:0]  ALU_control;
  logic [4:0]  shiftAmount;
  logic        HiLoWE;
  logic [31:0] aluResult;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] A_eff;
  logic [31:0] B_eff;

  modport master (
    output RegA, RegB, OperandA, OperandB,
    output FwdReg1, FwdData1, FwdValid1,
    output FwdReg2, FwdData2, FwdValid2,
    output ALU_control, shiftAmount, HiLoWE,
    input  aluResult, HI, LO, A_eff, B_eff
  );

  modport slave (
    input  RegA, RegB, OperandA, OperandB,
    input  FwdReg1, FwdData1, FwdValid1,
    input  FwdReg2, FwdData2, FwdValid2,
    input  ALU_control, shiftAmount, HiLoWE,
    output aluResult, HI, LO, A_eff, B_eff
  );
endinterface

// File: rtl/alu_bypass_unit.sv
// Combinational ALU with operand bypass and registered HI/LO.
// Define FORWARDING_EN to enable the EXE/MEM bypass muxes.
module alu_bypass_unit #(
  parameter logic [4:0] FWD_ZERO_REG = 5'd0
) (
  input logic       CLK,
  input logic       RESET,
  alu_bypass_if.slave bus
);

`ifdef FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_ADDU  = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_SUBU  = 6'h03;
  localparam logic [5:0] OP_AND   = 6'h04;
  localparam logic [5:0] OP_OR    = 6'h05;
  localparam logic [5:0] OP_XOR   = 6'h06;
  localparam logic [5:0] OP_NOR   = 6'h07;
  localparam logic [5:0] OP_SLT   = 6'h08;
  localparam logic [5:0] OP_SLTU  = 6'h09;
  localparam logic [5:0] OP_SLL   = 6'h0A;
  localparam logic [5:0] OP_SRL   = 6'h0B;
  localparam logic [5:0] OP_SRA   = 6'h0C;
  localparam logic [5:0] OP_SLLV  = 6'h0D;
  localparam logic [5:0] OP_SRLV  = 6'h0E;
  localparam logic [5:0] OP_SRAV  = 6'h0F;
  localparam logic [5:0] OP_LUI   = 6'h10;
  localparam logic [5:0] OP_MULT  = 6'h11;
  localparam logic [5:0] OP_MULTU = 6'h12;
  localparam logic [5:0] OP_DIV   = 6'h13;
  localparam logic [5:0] OP_DIVU  = 6'h14;
  localparam logic [5:0] OP_MFHI  = 6'h15;
  localparam logic [5:0] OP_MFLO  = 6'h16;
  localparam logic [5:0] OP_MTHI  = 6'h17;
  localparam logic [5:0] OP_MTLO  = 6'h18;
  localparam logic [5:0] OP_PASSA = 6'h19;
  localparam logic [5:0] OP_PASSB = 6'h1A;

  function automatic logic [31:0] resolve(
    input logic [4:0]  r,
    input logic [31:0] opnd,
    input logic [4:0]  r1,
    input logic [31:0] d1,
    input logic        v1,
    input logic [4:0]  r2,
    input logic [31:0] d2,
    input logic        v2
  );
    logic live;
    live = FWD_EN && (r != FWD_ZERO_REG);
    if (live && v1 && (r1 == r))
      return d1;
    else if (live && v2 && (r2 == r))
      return d2;
    return opnd;
  endfunction

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] hi_n;
  logic [31:0] lo_n;
  logic [31:0] res;

  assign a = resolve(bus.RegA, bus.OperandA,
                     bus.FwdReg1, bus.FwdData1, bus.FwdValid1,
                     bus.FwdReg2, bus.FwdData2, bus.FwdValid2);
  assign b = resolve(bus.RegB, bus.OperandB,
                     bus.FwdReg1, bus.FwdData1, bus.FwdValid1,
                     bus.FwdReg2, bus.FwdData2, bus.FwdValid2);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Sign-magnitude divide: remainder follows the dividend's sign.
  logic        div_s;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    div_s = (bus.ALU_control == OP_DIV);
    a_neg = div_s & a[31];
    b_neg = div_s & b[31];
    ma    = a_neg ? (~a + 32'd1) : a;
    mb    = b_neg ? (~b + 32'd1) : b;
    uq    = 32'd0;
    ur    = 32'd0;
    if (mb != 32'd0) begin
      uq = ma / mb;
      ur = ma % mb;
    end
    quot  = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem   = a_neg ? (~ur + 32'd1) : ur;
  end

  always_comb begin
    res  = 32'd0;
    hi_n = hi_q;
    lo_n = lo_q;
    unique case (bus.ALU_control)
      OP_ADD, OP_ADDU: res = a + b;
      OP_SUB, OP_SUBU: res = a - b;
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOR:   res = ~(a | b);
      OP_SLT:   res = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:  res = {31'd0, a < b};
      OP_SLL:   res = b << bus.shiftAmount;
      OP_SRL:   res = b >> bus.shiftAmount;
      OP_SRA:   res = $unsigned($signed(b) >>> bus.shiftAmount);
      OP_SLLV:  res = b << a[4:0];
      OP_SRLV:  res = b >> a[4:0];
      OP_SRAV:  res = $unsigned($signed(b) >>> a[4:0]);
      OP_LUI:   res = {b[15:0], 16'h0};
      OP_MULT:  {hi_n, lo_n} = prod_s;
      OP_MULTU: {hi_n, lo_n} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          hi_n = a;
          lo_n = 32'hFFFF_FFFF;
        end else begin
          hi_n = rem;
          lo_n = quot;
        end
      end
      OP_MFHI:  res = hi_q;
      OP_MFLO:  res = lo_q;
      OP_MTHI:  hi_n = a;
      OP_MTLO:  lo_n = a;
      OP_PASSA: res = a;
      OP_PASSB: res = b;
      default:  res = 32'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (bus.HiLoWE) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

  assign bus.aluResult = res;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.A_eff     = a;
  assign bus.B_eff     = b;

endmodule

// File: tb/tb_alu_bypass_unit.sv
// Scoreboard bench for alu_bypass_unit: random ops against a
// plain-arithmetic model, plus directed corner cases.
module tb_alu_bypass_unit;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  alu_bypass_if bus ();

  alu_bypass_unit dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  ra, rb;
    logic [31:0] oa, ob;
    logic [4:0]  f1r;
    logic [31:0] f1d;
    logic        f1v;
    logic [4:0]  f2r;
    logic [31:0] f2d;
    logic        f2v;
    logic [5:0]  op;
    logic [4:0]  sh;
    logic        we;
  } stim_t;

  typedef struct {
    logic [31:0] res, ae, be, hi, lo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          issued = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t blank();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [31:0] pick(input stim_t s, input logic [4:0] r,
                                       input logic [31:0] o);
`ifdef FORWARDING_EN
    if (r != 5'd0) begin
      if (s.f1v && s.f1r == r) return s.f1d;
      if (s.f2v && s.f2r == r) return s.f2d;
    end
`endif
    return o;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input stim_t s);
    logic [31:0] a, b, res, nh, nl;
    longint      sa, sbv, q, r;
    logic [63:0] p;
    exp_t        e;
    bus.RegA = s.ra;         bus.RegB = s.rb;
    bus.OperandA = s.oa;     bus.OperandB = s.ob;
    bus.FwdReg1 = s.f1r;     bus.FwdData1 = s.f1d;
    bus.FwdValid1 = s.f1v;   bus.FwdReg2 = s.f2r;
    bus.FwdData2 = s.f2d;    bus.FwdValid2 = s.f2v;
    bus.ALU_control = s.op;  bus.shiftAmount = s.sh;
    bus.HiLoWE = s.we;
    a = pick(s, s.ra, s.oa);
    b = pick(s, s.rb, s.ob);
    sa = $signed(a);
    sbv = $signed(b);
    res = 32'd0;
    nh = m_hi;
    nl = m_lo;
    case (s.op)
      6'h00, 6'h01: res = a + b;
      6'h02, 6'h03: res = a - b;
      6'h04: res = a & b;
      6'h05: res = a | b;
      6'h06: res = a ^ b;
      6'h07: res = ~(a | b);
      6'h08: res = (sa < sbv) ? 32'd1 : 32'd0;
      6'h09: res = (a < b) ? 32'd1 : 32'd0;
      6'h0A: res = b << s.sh;
      6'h0B: res = b >> s.sh;
      6'h0C: res = 32'(sbv >>> s.sh);
      6'h0D: res = b << a[4:0];
      6'h0E: res = b >> a[4:0];
      6'h0F: res = 32'(sbv >>> a[4:0]);
      6'h10: res = {b[15:0], 16'h0};
      6'h11: begin p = 64'(sa * sbv); nh = p[63:32]; nl = p[31:0]; end
      6'h12: begin p = 64'(a) * 64'(b); nh = p[63:32]; nl = p[31:0]; end
      6'h13: begin
        if (b == 0) begin nh = a; nl = 32'hFFFF_FFFF; end
        else begin q = sa / sbv; r = sa % sbv; nl = 32'(q); nh = 32'(r); end
      end
      6'h14: begin
        if (b == 0) begin nh = a; nl = 32'hFFFF_FFFF; end
        else begin nl = a / b; nh = a % b; end
      end
      6'h15: res = m_hi;
      6'h16: res = m_lo;
      6'h17: nh = a;
      6'h18: nl = a;
      6'h19: res = a;
      6'h1A: res = b;
      default: res = 32'd0;
    endcase
    e = '{res: res, ae: a, be: b, hi: m_hi, lo: m_lo};
    sb_q.push_back(e);
    issued = 1'b1;
    @(posedge CLK);
    if (s.we) begin
      m_hi = nh;
      m_lo = nl;
    end
    #1;
    issued = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (issued) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("aluResult", bus.aluResult, e.res);
        chk("A_eff", bus.A_eff, e.ae);
        chk("B_eff", bus.B_eff, e.be);
        chk("HI", bus.HI, e.hi);
        chk("LO", bus.LO, e.lo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    issue_init();
    #3;
    chk("reset_HI", bus.HI, 32'd0);
    chk("reset_LO", bus.LO, 32'd0);
    #4 RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Forward priority
    s = blank();
    s.ra = 5'd5; s.oa = 32'd1; s.op = 6'h19;
    s.f1r = 5'd5; s.f1d = 32'hAA; s.f1v = 1'b1;
    s.f2r = 5'd5; s.f2d = 32'hBB; s.f2v = 1'b1;
    issue(s);
`ifdef FORWARDING_EN
    chk("fwd_set1", bus.A_eff, 32'hAA);
`else
    chk("fwd_set1", bus.A_eff, 32'h1);
`endif
    s.f1v = 1'b0;
    issue(s);
`ifdef FORWARDING_EN
    chk("fwd_set2", bus.A_eff, 32'hBB);
`else
    chk("fwd_set2", bus.A_eff, 32'h1);
`endif
    s.f2v = 1'b0;
    issue(s);
    chk("fwd_none", bus.A_eff, 32'h1);

    // Zero register never forwarded
    s = blank();
    s.rb = 5'd0; s.f1r = 5'd0; s.f1d = 32'h1234; s.f1v = 1'b1;
    s.op = 6'h1A;
    issue(s);
    chk("zero_reg", bus.B_eff, 32'h0);

    // MULT then MFLO
    s = blank();
    s.oa = 32'hFFFF_FFFE; s.ob = 32'd3; s.op = 6'h11; s.we = 1'b1;
    issue(s);
    chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
    chk("mult_LO", bus.LO, 32'hFFFF_FFFA);
    s.op = 6'h16; s.we = 1'b0;
    issue(s);
    chk("mflo", bus.aluResult, 32'hFFFF_FFFA);

    // Divides
    s = blank();
    s.oa = 32'hFFFF_FFF9; s.ob = 32'd2; s.op = 6'h13; s.we = 1'b1;
    issue(s);
    chk("div_LO", bus.LO, 32'hFFFF_FFFD);
    chk("div_HI", bus.HI, 32'hFFFF_FFFF);
    s.oa = 32'd7; s.ob = 32'd0; s.op = 6'h14;
    issue(s);
    chk("divu0_LO", bus.LO, 32'hFFFF_FFFF);
    chk("divu0_HI", bus.HI, 32'd7);
    s.oa = 32'h8000_0000; s.ob = 32'hFFFF_FFFF; s.op = 6'h13;
    issue(s);
    chk("divovf_LO", bus.LO, 32'h8000_0000);
    chk("divovf_HI", bus.HI, 32'd0);

    // Shifts and compares
    s = blank();
    s.ob = 32'h8000_0000; s.sh = 5'd4; s.op = 6'h0C;
    issue(s);
    chk("sra", bus.aluResult, 32'hF800_0000);
    s = blank();
    s.oa = 32'd1; s.ob = 32'hFFFF_FFFF; s.op = 6'h09;
    issue(s);
    chk("sltu", bus.aluResult, 32'd1);
    s.op = 6'h08;
    issue(s);
    chk("slt", bus.aluResult, 32'd0);

    // Mid-cycle reset, reset overriding HiLoWE, then write-enable gating
    s = blank();
    s.oa = 32'h1234_5678; s.op = 6'h17; s.we = 1'b1;
    issue(s);
    chk("mthi", bus.HI, 32'h1234_5678);
    #2 RESET = 1'b0;
    #1;
    chk("async_HI", bus.HI, 32'd0);
    chk("async_LO", bus.LO, 32'd0);
    bus.OperandA = 32'h5; bus.HiLoWE = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_override", bus.HI, 32'd0);
    RESET = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    s.oa = 32'hDEAD; s.we = 1'b0;
    issue(s);
    chk("mthi_no_we", bus.HI, 32'd0);
    s.op = 6'h18; s.we = 1'b1; s.oa = 32'h4321;
    issue(s);
    chk("mtlo_first", bus.LO, 32'h4321);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s.ra  = 5'($urandom_range(0, 3));
      s.rb  = 5'($urandom_range(0, 3));
      s.oa  = rnd32();
      s.ob  = rnd32();
      s.f1r = 5'($urandom_range(0, 3));
      s.f1d = rnd32();
      s.f1v = 1'($urandom_range(0, 1));
      s.f2r = 5'($urandom_range(0, 3));
      s.f2d = rnd32();
      s.f2v = 1'($urandom_range(0, 1));
      s.op  = 6'($urandom_range(0, 31));
      s.sh  = 5'($urandom);
      s.we  = 1'($urandom_range(0, 1));
      issue(s);
    end

    @(negedge CLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic issue_init();
    bus.RegA = '0;       bus.RegB = '0;
    bus.OperandA = '0;   bus.OperandB = '0;
    bus.FwdReg1 = '0;    bus.FwdData1 = '0;
    bus.FwdValid1 = 1'b0;
    bus.FwdReg2 = '0;    bus.FwdData2 = '0;
    bus.FwdValid2 = 1'b0;
    bus.ALU_control = '0;
    bus.shiftAmount = '0;
    bus.HiLoWE = 1'b1;
  endtask

endmodule

// File: doc/alu_bypass_unit.md
ALU_BYPASS_UNIT -- requirements
Module: alu_bypass_unit

Interface
REQ-001 Parameter: FWD_ZERO_REG, default 0; register index that is never forwarded.
REQ-002 Reset RESET, asynchronous, active-low; clock CLK.
REQ-003 CLK  in  1  rising edge updates HI/LO.
REQ-004 RESET  in  1  async active-low; clears HI/LO.
REQ-005 RegA, RegB  in  5 each  source register indices of operands A and B.
REQ-006 OperandA, OperandB  in  32 each  register-file values.
REQ-007 FwdReg1, FwdData1, FwdValid1  in  5/32/1  first-priority bypass (EXE result).
REQ-008 FwdReg2, FwdData2, FwdValid2  in  5/32/1  second-priority bypass (MEM result).
REQ-009 ALU_control  in  6  operation select (REQ-015).
REQ-010 shiftAmount  in  5  immediate shift amount.
REQ-011 HiLoWE  in  1  commit new HI/LO at the clock edge.
REQ-012 aluResult  out  32  combinational result.
REQ-013 HI, LO  out  32 each  current HI/LO register values.
REQ-014 A_eff, B_eff  out  32 each  resolved operands after bypass.

Function
REQ-015 Codes (hex): 00 ADD, 01 ADDU, 02 SUB, 03 SUBU, 04 AND, 05 OR, 06 XOR, 07 NOR, 08 SLT, 09 SLTU, 0A SLL, 0B SRL, 0C SRA, 0D SLLV, 0E SRLV, 0F SRAV, 10 LUI, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 MFHI, 16 MFLO, 17 MTHI, 18 MTLO, 19 PASSA, 1A PASSB.
REQ-016 Operand resolution per operand: FwdValid1 and FwdReg1==Reg and Reg!=FWD_ZERO_REG -> FwdData1; else same test on set 2 -> FwdData2; else OperandX.
REQ-017 Set 1 wins when both sets match the same register.
REQ-018 Operand resolution is purely combinational, with no latency.
REQ-019 ADD/ADDU/SUB/SUBU wrap modulo 2^32; no overflow trap or flag.
REQ-020 SLT is signed; SLTU is unsigned; both return 1 or 0.
REQ-021 SLL/SRL/SRA shift B by shiftAmount.
REQ-022 SLLV/SRLV/SRAV shift B by A[4:0].
REQ-023 SRA/SRAV replicate B[31].
REQ-024 LUI returns {B[15:0],16'h0}.
REQ-025 MULT/MULTU form the 64-bit signed/unsigned product; new HI=product[63:32], new LO=product[31:0].
REQ-026 DIV/DIVU set new LO=quotient and new HI=remainder, both truncated toward zero; remainder takes the dividend's sign.
REQ-027 Divide by zero sets new LO=32'hFFFFFFFF and new HI=A, with no exception.
REQ-028 DIV of 80000000 by FFFFFFFF sets LO=80000000 and HI=0.
REQ-029 MFHI/MFLO return the registered HI/LO.
REQ-030 MTHI sets new HI=A; MTLO sets new LO=A.
REQ-031 Non-HI/LO ops keep new HI/LO equal to the current values.
REQ-032 MULT, MULTU, DIV, DIVU, MTHI and MTLO return aluResult=0.
REQ-033 Undefined codes return aluResult=0 and leave HI/LO unchanged.
REQ-034 HI/LO load the new values on a rising CLK only when HiLoWE=1; otherwise they hold.
REQ-035 MFHI in the same cycle as a pending MULT reads the old HI (one-cycle HI/LO latency).

Reset
REQ-036 RESET low clears HI=0 and LO=0 immediately and asynchronously.
REQ-037 RESET low overrides HiLoWE.
REQ-038 aluResult and the operand outputs stay combinational during reset.
REQ-039 After RESET rises, the first update happens at the next rising CLK with HiLoWE=1.

Configuration
REQ-040 Macro FORWARDING_EN defined: bypass logic per REQ-016..018.
REQ-041 FORWARDING_EN undefined: A_eff=OperandA and B_eff=OperandB; bypass inputs are ignored but the ports remain.

Verification
REQ-042 Forward priority: RegA=5, OperandA=1, FwdReg1=5/FwdData1=AA/FwdValid1=1, FwdReg2=5/FwdData2=BB/FwdValid2=1 -> A_eff=AA; FwdValid1=0 -> BB; both invalid -> 1.
REQ-043 Zero register: RegB=0, FwdReg1=0, FwdValid1=1, OperandB=0 -> B_eff=0.
REQ-044 MULT with A=FFFFFFFE (-2), B=3, HiLoWE=1, then edge -> HI=FFFFFFFF, LO=FFFFFFFA; then MFLO -> aluResult=FFFFFFFA.
REQ-045 DIV with A=FFFFFFF9 (-7), B=2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU with A=7, B=0 -> LO=FFFFFFFF, HI=7.
REQ-046 SRA with B=80000000, shamt=4 -> F8000000; SLTU with A=1, B=FFFFFFFF -> 1; SLT with the same inputs -> 0.
REQ-047 HI=HI_val with RESET pulsed low mid-cycle -> HI=LO=0 before the next edge; MTHI with HiLoWE=0 -> HI unchanged.
